// File: rtl/oled_spi_receiver_if.sv
// -----------------------------------------------------------------------------
// oled_spi_receiver_if
// Bundles the 4-wire OLED SPI link and the decoded pixel/command outputs of the
// display-side receiver.
//   master : display controller side (drives the SPI pins, observes the outputs)
//   slave  : oled_spi_receiver (samples the SPI pins, drives the outputs)
// Signals:
//   spi_csn, spi_clk, spi_mosi, spi_dc, spi_resn : SPI link pads
//   pixel_we, pixel_x, pixel_y, pixel_data       : addressed pixel write strobe
//   frame_end                                    : last pixel of the window
//   cmd_valid, cmd_byte                          : received command byte strobe
// -----------------------------------------------------------------------------
interface oled_spi_receiver_if #(
    parameter int c_color_bits = 16,
    parameter int c_x_size     = 96,
    parameter int c_y_size     = 64,
    parameter int c_x_bits     = $clog2(c_x_size),
    parameter int c_y_bits     = $clog2(c_y_size)
);
    logic                    spi_csn;
    logic                    spi_clk;
    logic                    spi_mosi;
    logic                    spi_dc;
    logic                    spi_resn;
    logic                    pixel_we;
    logic [c_x_bits-1:0]     pixel_x;
    logic [c_y_bits-1:0]     pixel_y;
    logic [c_color_bits-1:0] pixel_data;
    logic                    frame_end;
    logic                    cmd_valid;
    logic [7:0]              cmd_byte;

    modport master (
        output spi_csn, spi_clk, spi_mosi, spi_dc, spi_resn,
        input  pixel_we, pixel_x, pixel_y, pixel_data, frame_end, cmd_valid, cmd_byte
    );

    modport slave (
        input  spi_csn, spi_clk, spi_mosi, spi_dc, spi_resn,
        output pixel_we, pixel_x, pixel_y, pixel_data, frame_end, cmd_valid, cmd_byte
    );
endinterface

// File: rtl/oled_spi_receiver.sv
// -----------------------------------------------------------------------------
// oled_spi_receiver
// Display-side end of an SSD1331/SSD1351-style 4-wire SPI link. The SPI pads are
// oversampled in the local clock domain, bytes are assembled MSB first, the
// column/row window commands (0x15 / 0x75) are decoded and pixel data bytes
// become addressed pixel writes that walk the current window.
// Ports:
//   clk   : local clock, at least 4x the SPI clock
//   reset : asynchronous, active-high
//   bus   : oled_spi_receiver_if.slave (SPI pads in, pixel/command strobes out)
// Timing: a byte's pixel_we / cmd_valid is registered 4 clk cycles after the
// pad rising edge of its last (LSB) bit: 2 synchronizer stages, 1 shift stage,
// 1 output stage.
// -----------------------------------------------------------------------------
module oled_spi_receiver #(
    parameter int c_color_bits = 16,
    parameter int c_x_size     = 96,
    parameter int c_y_size     = 64,
    parameter int c_x_bits     = $clog2(c_x_size),
    parameter int c_y_bits     = $clog2(c_y_size)
) (
    input  logic                  clk,
    input  logic                  reset,
    oled_spi_receiver_if.slave    bus
);

    // Bit positions inside the synchronizer vectors
    localparam int c_i_csn  = 0;
    localparam int c_i_clk  = 1;
    localparam int c_i_mosi = 2;
    localparam int c_i_dc   = 3;
    localparam int c_i_resn = 4;

    localparam logic [c_x_bits-1:0] c_x_last = c_x_bits'(c_x_size - 1);
    localparam logic [c_y_bits-1:0] c_y_last = c_y_bits'(c_y_size - 1);
    localparam bit                  c_byte_pixel = (c_color_bits == 8);

    typedef enum logic [2:0] {
        S_CMD   = 3'd0,
        S_COL_A = 3'd1,
        S_COL_B = 3'd2,
        S_ROW_A = 3'd3,
        S_ROW_B = 3'd4
    } state_t;

    // Synchronizers and edge history
    logic [4:0] pad_s;
    logic [4:0] sync1_r;
    logic [4:0] sync2_r;
    logic       sck_d_r;
    logic       csn_d_r;

    // Decoded synchronized controls
    logic       csn_s;
    logic       resn_s;
    logic       srst_s;
    logic       sck_rise_s;
    logic       accept_s;

    // Byte assembly
    logic [7:0] shift_r;
    logic [2:0] bit_cnt_r;
    logic       byte_done_r;
    logic       byte_dc_r;

    // Command FSM and window/pointer
    state_t              state_r;
    state_t              state_s;
    logic                cmd_s;
    logic                data_s;
    logic                pix_fire_s;
    logic [c_x_bits-1:0] col_start_r;
    logic [c_x_bits-1:0] col_end_r;
    logic [c_y_bits-1:0] row_start_r;
    logic [c_y_bits-1:0] row_end_r;
    logic [c_x_bits-1:0] x_r;
    logic [c_y_bits-1:0] y_r;
    logic [c_x_bits-1:0] x_next_s;
    logic [c_y_bits-1:0] y_next_s;
    logic                frame_s;
    logic                phase_r;
    logic [7:0]          data_hi_r;
    logic [c_color_bits-1:0] pixel_value_s;

    // Registered outputs
    logic                    pixel_we_r;
    logic [c_x_bits-1:0]     pixel_x_r;
    logic [c_y_bits-1:0]     pixel_y_r;
    logic [c_color_bits-1:0] pixel_data_r;
    logic                    frame_end_r;
    logic                    cmd_valid_r;
    logic [7:0]              cmd_byte_r;

    assign pad_s = {bus.spi_resn, bus.spi_dc, bus.spi_mosi, bus.spi_clk, bus.spi_csn};

    // Two-stage synchronizer plus one history stage for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 5'b00000;
            sync2_r <= 5'b00000;
            sck_d_r <= 1'b0;
            csn_d_r <= 1'b0;
        end else begin
            sync1_r <= pad_s;
            sync2_r <= sync1_r;
            sck_d_r <= sync2_r[c_i_clk];
            csn_d_r <= sync2_r[c_i_csn];
        end
    end

    // Rise detection and bit acceptance.
    // A rise is still accepted in the cycle csn goes high so that a byte whose
    // 8th edge coincides with deselect completes before the counter clears.
    always_comb begin
        csn_s      = sync2_r[c_i_csn];
        resn_s     = sync2_r[c_i_resn];
        srst_s     = ~resn_s;
        sck_rise_s = sync2_r[c_i_clk] & ~sck_d_r;
        accept_s   = sck_rise_s & ~(csn_s & csn_d_r) & resn_s;
    end

    // Shift register, bit counter and byte-complete strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_r     <= 8'h00;
            bit_cnt_r   <= 3'd0;
            byte_done_r <= 1'b0;
            byte_dc_r   <= 1'b0;
        end else if (srst_s) begin
            shift_r     <= 8'h00;
            bit_cnt_r   <= 3'd0;
            byte_done_r <= 1'b0;
            byte_dc_r   <= 1'b0;
        end else begin
            byte_done_r <= 1'b0;
            if (accept_s) begin
                shift_r <= {shift_r[6:0], sync2_r[c_i_mosi]};
                if (bit_cnt_r == 3'd7) begin
                    bit_cnt_r   <= 3'd0;
                    byte_done_r <= 1'b1;
                    byte_dc_r   <= sync2_r[c_i_dc];
                end else begin
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                end
            end else if (csn_s) begin
                // deselected: drop any partial byte
                bit_cnt_r <= 3'd0;
            end
        end
    end

    // Byte classification; data bytes are only honoured outside parameter states
    always_comb begin
        cmd_s  = byte_done_r & ~byte_dc_r;
        data_s = byte_done_r & byte_dc_r & (state_r == S_CMD);
        if (c_byte_pixel) begin
            pix_fire_s = data_s;
        end else begin
            pix_fire_s = data_s & phase_r;
        end
    end

    // Command FSM next-state logic
    always_comb begin
        state_s = state_r;
        if (cmd_s) begin
            case (state_r)
                S_CMD: begin
                    if (shift_r == 8'h15) begin
                        state_s = S_COL_A;
                    end else if (shift_r == 8'h75) begin
                        state_s = S_ROW_A;
                    end else begin
                        state_s = S_CMD;
                    end
                end
                S_COL_A: state_s = S_COL_B;
                S_COL_B: state_s = S_CMD;
                S_ROW_A: state_s = S_ROW_B;
                S_ROW_B: state_s = S_CMD;
                default: state_s = S_CMD;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Command FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_CMD;
        end else if (srst_s) begin
            state_r <= S_CMD;
        end else begin
            state_r <= state_s;
        end
    end

    // Window walk: x wraps to col_start at col_end, y likewise at row_end.
    // Out-of-range windows simply count modulo 2^bits until the end value.
    always_comb begin
        frame_s = 1'b0;
        if (x_r == col_end_r) begin
            x_next_s = col_start_r;
            if (y_r == row_end_r) begin
                y_next_s = row_start_r;
                frame_s  = 1'b1;
            end else begin
                y_next_s = y_r + c_y_bits'(1);
            end
        end else begin
            x_next_s = x_r + c_x_bits'(1);
            y_next_s = y_r;
        end
    end

    // Pixel value: one byte per pixel, or held high byte plus current byte
    generate
        if (c_color_bits == 8) begin : g_px8
            always_comb pixel_value_s = shift_r;
        end else begin : g_px16
            always_comb pixel_value_s = {data_hi_r, shift_r};
        end
    endgenerate

    // Window registers, pointer, pixel phase and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_start_r  <= '0;
            col_end_r    <= c_x_last;
            row_start_r  <= '0;
            row_end_r    <= c_y_last;
            x_r          <= '0;
            y_r          <= '0;
            phase_r      <= 1'b0;
            data_hi_r    <= 8'h00;
            pixel_we_r   <= 1'b0;
            pixel_x_r    <= '0;
            pixel_y_r    <= '0;
            pixel_data_r <= '0;
            frame_end_r  <= 1'b0;
            cmd_valid_r  <= 1'b0;
            cmd_byte_r   <= 8'h00;
        end else if (srst_s) begin
            col_start_r  <= '0;
            col_end_r    <= c_x_last;
            row_start_r  <= '0;
            row_end_r    <= c_y_last;
            x_r          <= '0;
            y_r          <= '0;
            phase_r      <= 1'b0;
            data_hi_r    <= 8'h00;
            pixel_we_r   <= 1'b0;
            pixel_x_r    <= '0;
            pixel_y_r    <= '0;
            pixel_data_r <= '0;
            frame_end_r  <= 1'b0;
            cmd_valid_r  <= 1'b0;
            cmd_byte_r   <= 8'h00;
        end else begin
            pixel_we_r  <= pix_fire_s;
            frame_end_r <= pix_fire_s & frame_s;
            cmd_valid_r <= cmd_s;

            if (cmd_s) begin
                cmd_byte_r <= shift_r;
                // any command realigns the two-byte pixel phase
                phase_r    <= 1'b0;
                case (state_r)
                    S_COL_A: col_start_r <= shift_r[c_x_bits-1:0];
                    S_COL_B: begin
                        col_end_r <= shift_r[c_x_bits-1:0];
                        x_r       <= col_start_r;
                    end
                    S_ROW_A: row_start_r <= shift_r[c_y_bits-1:0];
                    S_ROW_B: begin
                        row_end_r <= shift_r[c_y_bits-1:0];
                        y_r       <= row_start_r;
                    end
                    default: begin
                        col_start_r <= col_start_r;
                    end
                endcase
            end else if (pix_fire_s) begin
                phase_r      <= 1'b0;
                pixel_x_r    <= x_r;
                pixel_y_r    <= y_r;
                pixel_data_r <= pixel_value_s;
                x_r          <= x_next_s;
                y_r          <= y_next_s;
            end else if (data_s) begin
                // first byte of a two-byte pixel
                data_hi_r <= shift_r;
                phase_r   <= 1'b1;
            end
        end
    end

    assign bus.pixel_we   = pixel_we_r;
    assign bus.pixel_x    = pixel_x_r;
    assign bus.pixel_y    = pixel_y_r;
    assign bus.pixel_data = pixel_data_r;
    assign bus.frame_end  = frame_end_r;
    assign bus.cmd_valid  = cmd_valid_r;
    assign bus.cmd_byte   = cmd_byte_r;

endmodule

// File: tb/tb_oled_spi_receiver.sv
// -----------------------------------------------------------------------------
// tb_oled_spi_receiver
// Drives the SPI link bit by bit (4 clk per SPI bit), predicts every strobe of
// oled_spi_receiver with a transaction-level display model and checks the DUT
// outputs on every clock. Directed literal checks pin the model's results.
// -----------------------------------------------------------------------------
module tb_oled_spi_receiver;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    oled_spi_receiver_if #(.c_color_bits(16), .c_x_size(96), .c_y_size(64)) bus ();

    oled_spi_receiver #(.c_color_bits(16), .c_x_size(96), .c_y_size(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int cyc;
        bit is_pix;
        int x;
        int y;
        int data;
        bit fe;
        int cb;
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  lsb_cyc = 0;

    // Observed strobe history
    int n_pix = 0, n_cmd = 0, n_fe = 0;
    int last_x = -1, last_y = -1, last_data = -1, last_fe = 0, last_cmd = -1, last_pix_cyc = 0;

    // Display model state
    int wx0, wx1, wy0, wy1, px, py, hi, pend_cmd, pend_cnt, p0;
    bit have_hi;

    function automatic void model_reset();
        wx0 = 0; wx1 = 95; wy0 = 0; wy1 = 63;
        px = 0; py = 0; have_hi = 1'b0; hi = 0;
        pend_cmd = 0; pend_cnt = 0; p0 = 0;
    endfunction

    function automatic void model_byte(input int b, input bit dc, input int at);
        ev_t e;
        e.cyc = at; e.is_pix = 1'b0; e.x = 0; e.y = 0; e.data = 0; e.fe = 1'b0; e.cb = b;
        if (!dc) begin
            q.push_back(e);
            have_hi = 1'b0;
            if (pend_cmd != 0) begin
                if (pend_cnt == 0) begin
                    p0 = b; pend_cnt = 1;
                end else begin
                    if (pend_cmd == 'h15) begin wx0 = p0 % 128; wx1 = b % 128; px = wx0; end
                    else begin wy0 = p0 % 64; wy1 = b % 64; py = wy0; end
                    pend_cmd = 0; pend_cnt = 0;
                end
            end else if (b == 'h15 || b == 'h75) begin
                pend_cmd = b;
            end
        end else if (pend_cmd == 0) begin
            if (!have_hi) begin
                hi = b; have_hi = 1'b1;
            end else begin
                have_hi = 1'b0;
                e.is_pix = 1'b1; e.x = px; e.y = py; e.data = hi * 256 + b;
                e.fe = (px == wx1) && (py == wy1);
                q.push_back(e);
                if (px == wx1) begin
                    px = wx0;
                    py = (py == wy1) ? wy0 : (py + 1) % 64;
                end else begin
                    px = (px + 1) % 128;
                end
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model's event queue
    initial begin
        ev_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.pixel_we) begin
                n_pix++; last_x = int'(bus.pixel_x); last_y = int'(bus.pixel_y);
                last_data = int'(bus.pixel_data); last_fe = int'(bus.frame_end); last_pix_cyc = cyc;
                if (bus.frame_end) n_fe++;
            end
            if (bus.cmd_valid) begin
                n_cmd++; last_cmd = int'(bus.cmd_byte);
            end
            total++;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                if (e.is_pix) begin
                    if (!(bus.pixel_we && !bus.cmd_valid && int'(bus.pixel_x) == e.x &&
                          int'(bus.pixel_y) == e.y && int'(bus.pixel_data) == e.data &&
                          bus.frame_end == e.fe)) begin
                        bad++;
                        $display("FAIL pixel @%0d: got we=%0b x=%0d y=%0d d=%0h fe=%0b want we=1 x=%0d y=%0d d=%0h fe=%0b",
                                 cyc, bus.pixel_we, bus.pixel_x, bus.pixel_y, bus.pixel_data,
                                 bus.frame_end, e.x, e.y, e.data, e.fe);
                    end
                end else begin
                    if (!(bus.cmd_valid && !bus.pixel_we && !bus.frame_end && int'(bus.cmd_byte) == e.cb)) begin
                        bad++;
                        $display("FAIL cmd @%0d: got valid=%0b byte=%0h we=%0b want valid=1 byte=%0h",
                                 cyc, bus.cmd_valid, bus.cmd_byte, bus.pixel_we, e.cb);
                    end
                end
            end else if (bus.pixel_we || bus.cmd_valid || bus.frame_end) begin
                bad++;
                $display("FAIL idle @%0d: got we=%0b cmd=%0b fe=%0b want 0 0 0",
                         cyc, bus.pixel_we, bus.cmd_valid, bus.frame_end);
            end
        end
    end

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Shift out nbits of b MSB first; only complete bytes reach the model
    task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
        bus.spi_dc = dc;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk); bus.spi_mosi = b[7-i]; bus.spi_clk = 1'b0;
            @(negedge clk);
            @(negedge clk); bus.spi_clk = 1'b1;
            if (i == 7) begin
                lsb_cyc = cyc;
                model_byte(int'(b), dc, cyc + 4);
            end
            @(negedge clk);
        end
        @(negedge clk); bus.spi_clk = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic dc);
        send_bits(b, dc, 8);
    endtask

    int base_pix, base_cmd, base_fe;

    initial begin
        bus.spi_csn = 1'b1; bus.spi_clk = 1'b0; bus.spi_mosi = 1'b0;
        bus.spi_dc = 1'b0; bus.spi_resn = 1'b1;
        model_reset();
        wait_neg(4);
        chk("rst_we",   int'(bus.pixel_we), 0);
        chk("rst_x",    int'(bus.pixel_x), 0);
        chk("rst_y",    int'(bus.pixel_y), 0);
        chk("rst_data", int'(bus.pixel_data), 0);
        chk("rst_fe",   int'(bus.frame_end), 0);
        chk("rst_cmdv", int'(bus.cmd_valid), 0);
        chk("rst_cmdb", int'(bus.cmd_byte), 0);
        reset = 1'b0;
        wait_neg(6);
        bus.spi_csn = 1'b0;
        wait_neg(4);

        // single 16-bit pixel after reset
        send(8'hF8, 1'b1); send(8'h00, 1'b1);
        wait_neg(8);
        chk("t1_count", n_pix, 1);
        chk("t1_data", last_data, 'hF800);
        chk("t1_x", last_x, 0);
        chk("t1_y", last_y, 0);
        chk("t1_latency", last_pix_cyc - lsb_cyc, 4);

        // window 2..4 x 1..2, then 7 pixels
        base_cmd = n_cmd; base_pix = n_pix; base_fe = n_fe;
        send(8'h15, 1'b0); send(8'h02, 1'b0); send(8'h04, 1'b0);
        send(8'h75, 1'b0); send(8'h01, 1'b0); send(8'h02, 1'b0);
        wait_neg(8);
        chk("t2_cmds", n_cmd - base_cmd, 6);
        for (int i = 0; i < 6; i++) begin
            send(8'h10, 1'b1); send(8'(i), 1'b1);
        end
        wait_neg(8);
        chk("t2_six", n_pix - base_pix, 6);
        chk("t2_last_x", last_x, 4);
        chk("t2_last_y", last_y, 2);
        chk("t2_fe", n_fe - base_fe, 1);
        chk("t2_fe_last", last_fe, 1);
        send(8'h10, 1'b1); send(8'h06, 1'b1);
        wait_neg(8);
        chk("t2_wrap_x", last_x, 2);
        chk("t2_wrap_y", last_y, 1);

        // resn mid-frame with a half pixel pending
        send(8'h77, 1'b1);
        wait_neg(8);
        bus.spi_resn = 1'b0;
        wait_neg(8);
        model_reset();
        chk("resn_x", int'(bus.pixel_x), 0);
        chk("resn_data", int'(bus.pixel_data), 0);
        chk("resn_cmdb", int'(bus.cmd_byte), 0);
        bus.spi_resn = 1'b1;
        wait_neg(6);
        send(8'hAB, 1'b1); send(8'hCD, 1'b1);
        wait_neg(8);
        chk("resn_px_x", last_x, 0);
        chk("resn_px_y", last_y, 0);
        chk("resn_px_d", last_data, 'hABCD);

        // full-width rows 62..63; stray data byte during a parameter is ignored
        send(8'h15, 1'b0); send(8'h99, 1'b1); send(8'h00, 1'b0); send(8'h5F, 1'b0);
        send(8'h75, 1'b0); send(8'h3E, 1'b0); send(8'h3F, 1'b0);
        base_pix = n_pix; base_fe = n_fe;
        for (int i = 0; i < 192; i++) begin
            send(8'(i >> 8), 1'b1); send(8'(i), 1'b1);
        end
        wait_neg(8);
        chk("fr_count", n_pix - base_pix, 192);
        chk("fr_last_x", last_x, 95);
        chk("fr_last_y", last_y, 63);
        chk("fr_last_fe", last_fe, 1);
        chk("fr_fe_cnt", n_fe - base_fe, 1);
        send(8'h55, 1'b1); send(8'hAA, 1'b1);
        wait_neg(8);
        chk("fr_next_x", last_x, 0);
        chk("fr_next_y", last_y, 62);

        // deselect after 5 bits discards the partial byte
        base_cmd = n_cmd;
        send_bits(8'hFF, 1'b0, 5);
        bus.spi_csn = 1'b1;
        wait_neg(6);
        bus.spi_csn = 1'b0;
        wait_neg(4);
        send(8'hA5, 1'b0);
        wait_neg(8);
        chk("csn_cmds", n_cmd - base_cmd, 1);
        chk("csn_byte", last_cmd, 'hA5);

        // command between pixel bytes realigns the phase
        base_pix = n_pix;
        send(8'h12, 1'b1); send(8'hAF, 1'b0); send(8'h34, 1'b1); send(8'h56, 1'b1);
        wait_neg(8);
        chk("ph_count", n_pix - base_pix, 1);
        chk("ph_data", last_data, 'h3456);

        wait_neg(20);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
